// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parameterised memory game. A sequence of LEDs (one-hot
// elements drawn from a free-running LFSR) is shown, and the player must
// repeat it on the buttons. Each round adds one element until PROF elements
// have been repeated (win), a wrong or multi-button play occurs (loss), or,
// optionally, the player is too slow (timeout).
//
// Optional feature macro: JOGO_TIMEOUT_EN
//   defined   -> ESPERA cycle counter, FIM_TIMEOUT state and timeout flag exist
//   undefined -> ESPERA waits indefinitely and timeout is tied to 0
module jogo_memoria_param #(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int T_MOSTRA = 500,
    parameter int T_APAGA  = 250,
    parameter int T_LIMITE = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jogar,
    input  logic [N_BOTOES-1:0]     botoes,
    output logic [N_BOTOES-1:0]     leds,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic                    pronto,
    output logic [3:0]              db_estado,
    output logic [$clog2(PROF)-1:0] db_limite,
    output logic [$clog2(PROF)-1:0] db_endereco
);

    localparam int AW   = $clog2(PROF);
    localparam int TMAX = (T_MOSTRA > T_APAGA) ? T_MOSTRA : T_APAGA;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [AW-1:0] ULTIMO = AW'(PROF - 1);

    // State encoding doubles as the db_estado code
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        APAGA       = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMA     = 4'h7,
        ACRESCENTA  = 4'h8,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // One LFSR step for x^8 + x^6 + x^5 + x^4 + 1
    function automatic logic [7:0] lfsr_passo(input logic [7:0] v);
        lfsr_passo = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Sequence element: one-hot of (lfsr mod N_BOTOES)
    function automatic logic [N_BOTOES-1:0] gera_elem(input logic [7:0] v);
        logic [7:0]          idx;
        logic [N_BOTOES-1:0] um;
        idx       = v % 8'(N_BOTOES);
        um        = N_BOTOES'(1);
        gera_elem = um << idx;
    endfunction

    // True when exactly one bit is set
    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        eh_one_hot = (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
    endfunction

    estado_t             estado_r;
    estado_t             estado_nxt_s;
    logic [7:0]          lfsr_r;
    logic [TW-1:0]       tmr_r;
    logic [TW-1:0]       tmr_nxt_s;
    logic [AW-1:0]       endereco_r;
    logic [AW-1:0]       endereco_nxt_s;
    logic [AW-1:0]       limite_r;
    logic [AW-1:0]       limite_nxt_s;
    logic [N_BOTOES-1:0] botoes_ant_r;
    logic [N_BOTOES-1:0] jogada_r;
    logic [N_BOTOES-1:0] mem_r [PROF];
    logic                wr_en_s;
    logic [AW-1:0]       wr_addr_s;
    logic [N_BOTOES-1:0] wr_data_s;
    logic [N_BOTOES-1:0] mostra_s;
    logic                jogada_s;
    logic                acerto_s;
    logic                mostra_fim_s;
    logic                apaga_fim_s;
    logic [N_BOTOES-1:0] leds_nxt_s;
    logic                ganhou_nxt_s;
    logic                perdeu_nxt_s;
    logic                pronto_nxt_s;
    logic [N_BOTOES-1:0] leds_r;
    logic                ganhou_r;
    logic                perdeu_r;
    logic                pronto_r;

    assign jogada_s     = (botoes != '0) && (botoes_ant_r == '0);
    assign acerto_s     = eh_one_hot(jogada_r) && (jogada_r == mem_r[endereco_r]);
    assign mostra_fim_s = (tmr_r == TW'(T_MOSTRA - 1));
    assign apaga_fim_s  = (tmr_r == TW'(T_APAGA - 1));
    assign wr_data_s    = gera_elem(lfsr_r);

`ifdef JOGO_TIMEOUT_EN
    localparam int CW = $clog2(T_LIMITE + 1);
    logic [CW-1:0] espera_cnt_r;
    logic          limite_fim_s;
    logic          timeout_nxt_s;
    logic          timeout_r;

    assign limite_fim_s = (espera_cnt_r == CW'(T_LIMITE - 1));

    // ESPERA cycle counter; zero outside ESPERA and after every accepted play
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            espera_cnt_r <= '0;
        end else if ((estado_r == ESPERA) && !jogada_s && !limite_fim_s) begin
            espera_cnt_r <= espera_cnt_r + CW'(1);
        end else begin
            espera_cnt_r <= '0;
        end
    end

    assign timeout_nxt_s = (estado_nxt_s == FIM_TIMEOUT);

    // Timeout flag register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_nxt_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= estado_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        estado_nxt_s = estado_r;
        case (estado_r)
            INICIAL: begin
                if (jogar) estado_nxt_s = PREPARA;
                else       estado_nxt_s = INICIAL;
            end
            PREPARA:    estado_nxt_s = MOSTRA;
            MOSTRA: begin
                if (mostra_fim_s) estado_nxt_s = APAGA;
                else              estado_nxt_s = MOSTRA;
            end
            APAGA: begin
                if (!apaga_fim_s)                estado_nxt_s = APAGA;
                else if (endereco_r == limite_r) estado_nxt_s = ESPERA;
                else                             estado_nxt_s = MOSTRA;
            end
            ESPERA: begin
                // A play wins over a simultaneous terminal count
                if (jogada_s)          estado_nxt_s = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                else if (limite_fim_s) estado_nxt_s = FIM_TIMEOUT;
`endif
                else                   estado_nxt_s = ESPERA;
            end
            REGISTRA:   estado_nxt_s = COMPARA;
            COMPARA: begin
                if (!acerto_s)                   estado_nxt_s = FIM_ERRO;
                else if (endereco_r != limite_r) estado_nxt_s = PROXIMA;
                else if (limite_r != ULTIMO)     estado_nxt_s = ACRESCENTA;
                else                             estado_nxt_s = FIM_ACERTO;
            end
            PROXIMA:    estado_nxt_s = ESPERA;
            ACRESCENTA: estado_nxt_s = MOSTRA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (jogar) estado_nxt_s = PREPARA;
                else       estado_nxt_s = estado_r;
            end
            default:    estado_nxt_s = INICIAL;
        endcase
    end

    // Datapath next values: display timer, pointers and memory write port
    always_comb begin
        tmr_nxt_s      = '0;
        endereco_nxt_s = endereco_r;
        limite_nxt_s   = limite_r;
        wr_en_s        = 1'b0;
        wr_addr_s      = limite_r;
        case (estado_r)
            PREPARA: begin
                endereco_nxt_s = '0;
                limite_nxt_s   = '0;
                wr_en_s        = 1'b1;
                wr_addr_s      = '0;
            end
            MOSTRA: begin
                if (mostra_fim_s) tmr_nxt_s = '0;
                else              tmr_nxt_s = tmr_r + TW'(1);
            end
            APAGA: begin
                if (!apaga_fim_s) begin
                    tmr_nxt_s = tmr_r + TW'(1);
                end else if (endereco_r == limite_r) begin
                    endereco_nxt_s = '0;
                end else begin
                    endereco_nxt_s = endereco_r + AW'(1);
                end
            end
            PROXIMA:    endereco_nxt_s = endereco_r + AW'(1);
            ACRESCENTA: begin
                limite_nxt_s   = limite_r + AW'(1);
                endereco_nxt_s = '0;
                wr_en_s        = 1'b1;
                wr_addr_s      = limite_r + AW'(1);
            end
            default: begin
                tmr_nxt_s = '0;
            end
        endcase
    end

    // Datapath registers: timer, pointers, LFSR and button history
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr_r        <= '0;
            endereco_r   <= '0;
            limite_r     <= '0;
            lfsr_r       <= 8'h01;
            botoes_ant_r <= '0;
            jogada_r     <= '0;
        end else begin
            tmr_r        <= tmr_nxt_s;
            endereco_r   <= endereco_nxt_s;
            limite_r     <= limite_nxt_s;
            lfsr_r       <= lfsr_passo(lfsr_r);
            botoes_ant_r <= botoes;
            if (estado_r == REGISTRA) jogada_r <= botoes;
            else                      jogada_r <= jogada_r;
        end
    end

    // Sequence memory; contents survive reset on purpose
    always_ff @(posedge clock) begin
        if (wr_en_s) mem_r[wr_addr_s] <= wr_data_s;
    end

    // Element to show next cycle, forwarding a write to the same address
    always_comb begin
        if (wr_en_s && (wr_addr_s == endereco_nxt_s)) mostra_s = wr_data_s;
        else                                          mostra_s = mem_r[endereco_nxt_s];
    end

    // Output logic: values implied by the next state
    always_comb begin
        leds_nxt_s   = '0;
        ganhou_nxt_s = 1'b0;
        perdeu_nxt_s = 1'b0;
        pronto_nxt_s = 1'b0;
        if (estado_nxt_s == MOSTRA) leds_nxt_s = mostra_s;
        else                        leds_nxt_s = '0;
        case (estado_nxt_s)
            FIM_ACERTO: begin
                ganhou_nxt_s = 1'b1;
                pronto_nxt_s = 1'b1;
            end
            FIM_ERRO: begin
                perdeu_nxt_s = 1'b1;
                pronto_nxt_s = 1'b1;
            end
            FIM_TIMEOUT: pronto_nxt_s = 1'b1;
            default:     pronto_nxt_s = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_r   <= '0;
            ganhou_r <= 1'b0;
            perdeu_r <= 1'b0;
            pronto_r <= 1'b0;
        end else begin
            leds_r   <= leds_nxt_s;
            ganhou_r <= ganhou_nxt_s;
            perdeu_r <= perdeu_nxt_s;
            pronto_r <= pronto_nxt_s;
        end
    end

    assign leds        = leds_r;
    assign ganhou      = ganhou_r;
    assign perdeu      = perdeu_r;
    assign pronto      = pronto_r;
    assign db_estado   = estado_r;
    assign db_limite   = limite_r;
    assign db_endereco = endereco_r;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Testbench for jogo_memoria_param (N_BOTOES=4, PROF=4, T_MOSTRA=2,
// T_APAGA=1, T_LIMITE=20). A reference LFSR and an expected-sequence array
// predict every displayed element; game flow is checked step by step.
module tb_jogo_memoria_param;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int TM = 2;
    localparam int TA = 1;
    localparam int TL = 20;

    logic         clock;
    logic         reset;
    logic         jogar;
    logic [N-1:0] botoes;
    logic [N-1:0] leds;
    logic         ganhou;
    logic         perdeu;
    logic         timeout;
    logic         pronto;
    logic [3:0]   db_estado;
    logic [1:0]   db_limite;
    logic [1:0]   db_endereco;

    jogo_memoria_param #(
        .N_BOTOES(N), .PROF(P), .T_MOSTRA(TM), .T_APAGA(TA), .T_LIMITE(TL)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .pronto(pronto), .db_estado(db_estado), .db_limite(db_limite),
        .db_endereco(db_endereco)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0]   m_lfsr;
    logic [N-1:0] exp_mem [P];

    // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of tapped bits
    function automatic logic [7:0] ref_step(input logic [7:0] v);
        logic [7:0] taps;
        taps     = 8'b1011_1000;
        ref_step = {v[6:0], ^(v & taps)};
    endfunction

    function automatic logic [N-1:0] elem_of(input logic [7:0] v);
        logic [N-1:0] one;
        int           idx;
        one     = 1;
        idx     = int'(v) % N;
        elem_of = one << idx;
    endfunction

    // Reference LFSR: runs every clock from the seed after reset
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'h01;
        else        m_lfsr <= ref_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic g, input logic p,
                             input logic t, input logic r);
        chk({tag, "_ganhou"}, 32'(ganhou), 32'(g));
        chk({tag, "_perdeu"}, 32'(perdeu), 32'(p));
        chk({tag, "_timeout"}, 32'(timeout), 32'(t));
        chk({tag, "_pronto"}, 32'(pronto), 32'(r));
    endtask

    // From INICIAL or a FIM state: request a game, land in PREPARA
    task automatic start_game();
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        chk("prepara", 32'(db_estado), 32'h1);
        chk_flags("prepara", 1'b0, 1'b0, 1'b0, 1'b0);
        exp_mem[0] = elem_of(m_lfsr);
    endtask

    // Follow one full replay of elements 0..lim, ending in ESPERA
    task automatic watch_display(input int lim, input bit noise);
        for (int i = 0; i <= lim; i++) begin
            for (int c = 0; c < TM; c++) begin
                @(negedge clock);
                chk("leds_on", 32'(leds), 32'(exp_mem[i]));
                if (noise) begin
                    if (i == lim && c == TM - 1) botoes = '0;
                    else                          botoes = N'($urandom_range(0, 15));
                end
            end
            for (int c = 0; c < TA; c++) begin
                @(negedge clock);
                chk("leds_off", 32'(leds), 32'h0);
            end
        end
        @(negedge clock);
        chk("espera", 32'(db_estado), 32'h4);
        chk("espera_limite", 32'(db_limite), 32'(lim));
        chk("espera_endereco", 32'(db_endereco), 32'h0);
    endtask

    task automatic wait_random();
        int n;
        n = $urandom_range(0, 6);
        repeat (n) begin
            @(negedge clock);
            chk("espera_idle", 32'(db_estado), 32'h4);
        end
    endtask

    // Press from ESPERA; returns at the negedge after the compare
    task automatic press(input logic [N-1:0] v);
        botoes = v;
        @(negedge clock);
        chk("registra", 32'(db_estado), 32'h5);
        @(negedge clock);
        chk("compara", 32'(db_estado), 32'h6);
        botoes = '0;
        @(negedge clock);
    endtask

    // Full game; fail_round < 0 means play perfectly. fail_val 0 means a
    // wrong single button, otherwise that exact value is pressed.
    task automatic run_game(input int fail_round, input int fail_idx,
                            input logic [N-1:0] fail_val, input bit noise);
        logic [N-1:0] e;
        start_game();
        watch_display(0, noise);
        for (int r = 0; r < P; r++) begin
            for (int i = 0; i <= r; i++) begin
                wait_random();
                if (r == fail_round && i == fail_idx) begin
                    e = exp_mem[i];
                    if (fail_val == '0) press({e[N-2:0], e[N-1]});
                    else                press(fail_val);
                    chk("fim_erro", 32'(db_estado), 32'hE);
                    chk_flags("fim_erro", 1'b0, 1'b1, 1'b0, 1'b1);
                    return;
                end
                press(exp_mem[i]);
                if (i < r) begin
                    chk("proxima", 32'(db_estado), 32'h7);
                    @(negedge clock);
                    chk("espera_next", 32'(db_estado), 32'h4);
                    chk("endereco_next", 32'(db_endereco), 32'(i + 1));
                end else if (r < P - 1) begin
                    chk("acrescenta", 32'(db_estado), 32'h8);
                    exp_mem[r + 1] = elem_of(m_lfsr);
                    watch_display(r + 1, noise);
                end else begin
                    chk("fim_acerto", 32'(db_estado), 32'hA);
                    chk("fim_acerto_limite", 32'(db_limite), 32'h3);
                    chk_flags("fim_acerto", 1'b1, 1'b0, 1'b0, 1'b1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] v;
        int           fr;
        reset  = 1'b0;
        jogar  = 1'b0;
        botoes = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_estado", 32'(db_estado), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_limite", 32'(db_limite), 32'h0);
        chk("rst_endereco", 32'(db_endereco), 32'h0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("inicial_idle", 32'(db_estado), 32'h0);

        // Perfect game with button noise outside ESPERA
        run_game(-1, 0, '0, 1'b1);
        // Wrong button in round 2 at endereco 1
        run_game(1, 1, '0, 1'b0);
        // Two buttons at once
        run_game(0, 0, 4'b0011, 1'b0);
        // Randomised losing games
        for (int g = 0; g < 3; g++) begin
            fr = $urandom_range(0, P - 1);
            if ($urandom_range(0, 1) == 1) begin
                v = '0;
            end else begin
                do v = N'($urandom_range(1, 15)); while ($countones(v) < 2);
            end
            run_game(fr, $urandom_range(0, fr), v, 1'b0);
        end
        run_game(-1, 0, '0, 1'b0);

        // Timeout behaviour
        start_game();
        watch_display(0, 1'b0);
`ifdef JOGO_TIMEOUT_EN
        repeat (TL - 1) @(negedge clock);
        chk("to_last_cycle", 32'(db_estado), 32'h4);
        press(exp_mem[0]);
        chk("to_play_wins", 32'(db_estado), 32'h8);
        exp_mem[1] = elem_of(m_lfsr);
        watch_display(1, 1'b0);
        repeat (TL - 1) @(negedge clock);
        chk("to_pre", 32'(db_estado), 32'h4);
        @(negedge clock);
        chk("to_estado", 32'(db_estado), 32'hF);
        chk_flags("to", 1'b0, 1'b0, 1'b1, 1'b1);
        start_game();
`else
        repeat (1000) @(negedge clock);
        chk("no_to_estado", 32'(db_estado), 32'h4);
        chk("no_to_flag", 32'(timeout), 32'h0);
        press(exp_mem[0]);
        chk("no_to_acrescenta", 32'(db_estado), 32'h8);
`endif

        // Asynchronous reset in the middle of MOSTRA
        @(negedge clock);
        chk("pre_reset_leds", 32'(leds), 32'(exp_mem[0]));
        #2 reset = 1'b0;
        #1;
        chk("async_leds", 32'(leds), 32'h0);
        chk("async_estado", 32'(db_estado), 32'h0);
        chk("async_limite", 32'(db_limite), 32'h0);
        chk("async_endereco", 32'(db_endereco), 32'h0);
        chk_flags("async", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", 32'(db_estado), 32'h0);
        run_game(2, 0, '0, 1'b0);
        run_game(-1, 0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
